// File: rtl/pwm_waveform_gen.sv
// Complementary PWM pair from an 8-bit duty value: prescaled 255-tick period,
// duty shadowed at period boundaries, dead time inserted around every output change.
module pwm_waveform_gen #(
  parameter int unsigned PRESCALE = 49,
  parameter int unsigned DEADTIME = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] duty_in,
  output logic       pwm_out,
  output logic       pwm_n_out,
  output logic       period_start,
  output logic [7:0] duty_active
);

  localparam int unsigned PW = ($clog2(PRESCALE + 1) < 1) ? 1 : $clog2(PRESCALE + 1);
  localparam int unsigned DW = ($clog2(DEADTIME + 1) < 1) ? 1 : $clog2(DEADTIME + 1);
  localparam int unsigned CW = 8;

  localparam logic [PW-1:0] PRE_MAX  = PW'(PRESCALE);
  localparam logic [DW-1:0] DT_LOAD  = DW'(DEADTIME);
  localparam logic [CW-1:0] CNT_LAST = CW'(254);
  localparam bit            DT_EN    = (DEADTIME != 0);
  // The cycle that detects a change is already the first blanked cycle.
  localparam logic [DW-1:0] DT_CHG   = DT_EN ? DW'(DEADTIME - 1) : '0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dt_cnt_q, dt_cnt_d;
  logic          committed_q, committed_d;
  logic          pwm_q, pwm_d;
  logic          pwm_n_q, pwm_n_d;
  logic          period_start_q, period_start_d;
  logic [CW-1:0] duty_active_q, duty_active_d;

  logic run_c;
  logic tick_c;
  logic wrap_c;
  logic raw_c;
  logic start_c;
  logic load_duty_c;

  assign run_c  = (state_q == ST_RUN);
  assign tick_c = run_c && (pre_cnt_q == PRE_MAX);
  assign wrap_c = tick_c && (cnt_q == CNT_LAST);
  assign raw_c  = run_c && (cnt_q < duty_active_q);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave RUN only at a wrap tick with enable low
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;
      ST_RUN:  if (wrap_c && !enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: period start strobes and shadow-duty load
  always_comb begin
    start_c     = 1'b0;
    load_duty_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start_c     = enable;
        load_duty_c = enable;
      end
      ST_RUN: begin
        load_duty_c = wrap_c && enable;
      end
      default: begin
        start_c     = 1'b0;
        load_duty_c = 1'b0;
      end
    endcase
  end

  // Counters, compare and dead-time output stage
  always_comb begin
    pre_cnt_d      = pre_cnt_q;
    cnt_d          = cnt_q;
    dt_cnt_d       = dt_cnt_q;
    committed_d    = committed_q;
    pwm_d          = 1'b0;
    pwm_n_d        = 1'b0;
    period_start_d = load_duty_c;
    duty_active_d  = load_duty_c ? duty_in : duty_active_q;

    if (!run_c) begin
      pre_cnt_d   = '0;
      cnt_d       = '0;
      committed_d = 1'b0;
      dt_cnt_d    = '0;
      if (start_c) begin
        // First compare of the new period is cnt=0 < duty_in
        committed_d = (duty_in != '0);
        dt_cnt_d    = DT_LOAD;
      end
    end else begin
      if (tick_c) begin
        pre_cnt_d = '0;
        cnt_d     = wrap_c ? '0 : cnt_q + CW'(1);
      end else begin
        pre_cnt_d = pre_cnt_q + PW'(1);
      end

      if (raw_c != committed_q) begin
        committed_d = raw_c;
        dt_cnt_d    = DT_CHG;
        if (!DT_EN) begin
          pwm_d   = raw_c;
          pwm_n_d = !raw_c;
        end
      end else if (dt_cnt_q != '0) begin
        dt_cnt_d = dt_cnt_q - DW'(1);
      end else begin
        pwm_d   = committed_q;
        pwm_n_d = !committed_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt_q      <= '0;
      cnt_q          <= '0;
      dt_cnt_q       <= '0;
      committed_q    <= 1'b0;
      pwm_q          <= 1'b0;
      pwm_n_q        <= 1'b0;
      period_start_q <= 1'b0;
      duty_active_q  <= '0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      cnt_q          <= cnt_d;
      dt_cnt_q       <= dt_cnt_d;
      committed_q    <= committed_d;
      pwm_q          <= pwm_d;
      pwm_n_q        <= pwm_n_d;
      period_start_q <= period_start_d;
      duty_active_q  <= duty_active_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign pwm_n_out    = pwm_n_q;
  assign period_start = period_start_q;
  assign duty_active  = duty_active_q;

endmodule

// File: tb/tb_pwm_waveform_gen.sv
// Bench for pwm_waveform_gen: two instances (fast PRESCALE=0/DEADTIME=0 and
// PRESCALE=49/DEADTIME=2) against a cycle-level reference model of the waveform.
module tb_pwm_waveform_gen;

  localparam int unsigned P0 = 0;
  localparam int unsigned D0 = 0;
  localparam int unsigned P1 = 49;
  localparam int unsigned D1 = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] duty_in = 8'd0;

  logic       pwm0, pwmn0, ps0;
  logic [7:0] da0;
  logic       pwm1, pwmn1, ps1;
  logic [7:0] da1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_waveform_gen #(.PRESCALE(P0), .DEADTIME(D0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .duty_in(duty_in),
    .pwm_out(pwm0), .pwm_n_out(pwmn0), .period_start(ps0), .duty_active(da0)
  );

  pwm_waveform_gen #(.PRESCALE(P1), .DEADTIME(D1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .duty_in(duty_in),
    .pwm_out(pwm1), .pwm_n_out(pwmn1), .period_start(ps1), .duty_active(da1)
  );

  // Reference model: clocks per tick, dead time, run flag, clk phase within period
  int  m_div  [2] = '{P0 + 1, P1 + 1};
  int  m_dt   [2] = '{D0, D1};
  bit  m_run  [2];
  int  m_ph   [2];
  int  m_duty [2];
  bit  m_ps   [2];
  int  m_stab [2];
  bit  m_last [2];
  bit  m_out  [2];
  bit  m_nout [2];
  bit  m_raw;

  // An output level is driven only once the ideal compare has been stable
  // for DEADTIME+1 consecutive samples since the block started running.
  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_run[k] = 1'b0; m_ph[k] = 0; m_duty[k] = 0; m_ps[k] = 1'b0;
        m_stab[k] = 0; m_last[k] = 1'b0; m_out[k] = 1'b0; m_nout[k] = 1'b0;
      end else begin
        m_raw = m_run[k] && ((m_ph[k] / m_div[k]) < m_duty[k]);
        if (!m_run[k]) begin
          m_stab[k] = 0;
          m_out[k]  = 1'b0;
          m_nout[k] = 1'b0;
        end else begin
          if (m_stab[k] == 0 || m_raw != m_last[k]) begin
            m_stab[k] = 1;
            m_last[k] = m_raw;
          end else if (m_stab[k] < 1000) begin
            m_stab[k]++;
          end
          m_out[k]  = (m_stab[k] >= m_dt[k] + 1) ? m_last[k]  : 1'b0;
          m_nout[k] = (m_stab[k] >= m_dt[k] + 1) ? !m_last[k] : 1'b0;
        end
        m_ps[k] = 1'b0;
        if (!m_run[k]) begin
          if (enable) begin
            m_run[k] = 1'b1; m_ph[k] = 0; m_duty[k] = int'(duty_in); m_ps[k] = 1'b1;
          end
        end else begin
          m_ph[k]++;
          if (m_ph[k] == 255 * m_div[k]) begin
            m_ph[k] = 0;
            if (enable) begin
              m_duty[k] = int'(duty_in);
              m_ps[k]   = 1'b1;
            end else begin
              m_run[k] = 1'b0;
            end
          end
        end
      end
    end
  end

  // Cycle-by-cycle scoreboard
  always @(negedge clk) begin
    n_checks++;
    if ({ps0, da0, pwm0, pwmn0} !== {m_ps[0], 8'(m_duty[0]), m_out[0], m_nout[0]}) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL model_dut0 t=%0t got ps=%b duty=%0d pwm=%b pwmn=%b expected ps=%b duty=%0d pwm=%b pwmn=%b",
                 $time, ps0, da0, pwm0, pwmn0, m_ps[0], m_duty[0], m_out[0], m_nout[0]);
    end
    n_checks++;
    if ({ps1, da1, pwm1, pwmn1} !== {m_ps[1], 8'(m_duty[1]), m_out[1], m_nout[1]}) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL model_dut1 t=%0t got ps=%b duty=%0d pwm=%b pwmn=%b expected ps=%b duty=%0d pwm=%b pwmn=%b",
                 $time, ps1, da1, pwm1, pwmn1, m_ps[1], m_duty[1], m_out[1], m_nout[1]);
    end
    n_checks++;
    if (((pwm0 & pwmn0) !== 1'b0) || ((pwm1 & pwmn1) !== 1'b0)) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL overlap t=%0t got dut0=%b%b dut1=%b%b expected never both high",
                 $time, pwm0, pwmn0, pwm1, pwmn1);
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog got no completion expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_ps(input int which, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (((which == 0) ? ps0 : ps1) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({pwm0, pwmn0, ps0, da0, pwm1, pwmn1, ps1, da1} !== 22'd0) begin
        n_fail++;
        $display("FAIL reset_state got %b expected all zero",
                 {pwm0, pwmn0, ps0, da0, pwm1, pwmn1, ps1, da1});
      end
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({pwm0, pwmn0, ps0, pwm1, pwmn1, ps1} !== 6'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset got %b expected 000000", {pwm0, pwmn0, ps0, pwm1, pwmn1, ps1});
    end
  endtask

  task automatic test_duty64();
    bit ok;
    int hi, bad, both_lo;
    duty_in = 8'd64;
    enable  = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ps0, ps1, da0} !== {1'b1, 1'b1, 8'd64}) begin
      n_fail++;
      $display("FAIL start_pulse got ps0=%b ps1=%b duty=%0d expected 1 1 64", ps0, ps1, da0);
    end
    wait_ps(0, 300, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ps0_timeout got none expected pulse within 300 clk"); end
    hi = 0; bad = 0;
    for (int i = 0; i < 255; i++) begin
      if (pwm0) hi++;
      if (pwmn0 !== ~pwm0) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (hi !== 64) begin n_fail++; $display("FAIL high_time_64 got %0d expected 64", hi); end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL complement got %0d bad cycles expected 0", bad); end
    n_checks++;
    if (ps0 !== 1'b1) begin n_fail++; $display("FAIL period_255 got ps0=%b expected 1", ps0); end

    wait_ps(1, 13000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ps1_timeout got none expected pulse within 13000 clk"); end
    hi = 0; both_lo = 0;
    for (int i = 0; i < 255 * (P1 + 1); i++) begin
      if (pwm1) hi++;
      if (!pwm1 && !pwmn1) both_lo++;
      @(negedge clk);
    end
    n_checks++;
    if (hi !== 64 * 50 - 2) begin n_fail++; $display("FAIL high_time_dt got %0d expected %0d", hi, 64 * 50 - 2); end
    n_checks++;
    if (both_lo !== 4) begin n_fail++; $display("FAIL dead_time got %0d expected 4", both_lo); end
    n_checks++;
    if (ps1 !== 1'b1) begin n_fail++; $display("FAIL period_12750 got ps1=%b expected 1", ps1); end
  endtask

  task automatic test_duty_change();
    bit ok;
    int hi, early;
    wait_ps(0, 300, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ps0_timeout got none expected pulse within 300 clk"); end
    hi = 0; early = 0;
    for (int i = 0; i < 255; i++) begin
      if (i == 10) duty_in = 8'd128;
      if (pwm0) hi++;
      if (da0 !== 8'd64) early++;
      @(negedge clk);
    end
    n_checks++;
    if (hi !== 64) begin n_fail++; $display("FAIL shadow_cur got %0d expected 64", hi); end
    n_checks++;
    if (early !== 0) begin n_fail++; $display("FAIL shadow_early got %0d cycles expected 0", early); end
    n_checks++;
    if ({ps0, da0} !== {1'b1, 8'd128}) begin
      n_fail++; $display("FAIL shadow_wrap got ps=%b duty=%0d expected 1 128", ps0, da0);
    end
    hi = 0;
    for (int i = 0; i < 255; i++) begin
      if (pwm0) hi++;
      @(negedge clk);
    end
    n_checks++;
    if (hi !== 128) begin n_fail++; $display("FAIL shadow_next got %0d expected 128", hi); end
  endtask

  task automatic test_extremes();
    bit ok;
    int hi, nhi;
    duty_in = 8'd0;
    wait_ps(0, 300, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ps0_timeout got none expected pulse within 300 clk"); end
    hi = 0; nhi = 0;
    for (int i = 0; i < 255; i++) begin
      if (pwm0) hi++;
      if (pwmn0) nhi++;
      @(negedge clk);
    end
    n_checks++;
    if ({hi, nhi} !== {32'd0, 32'd255}) begin
      n_fail++; $display("FAIL duty0 got hi=%0d nhi=%0d expected 0 255", hi, nhi);
    end
    duty_in = 8'd255;
    wait_ps(0, 300, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ps0_timeout got none expected pulse within 300 clk"); end
    @(negedge clk);
    hi = 0; nhi = 0;
    for (int i = 0; i < 255; i++) begin
      if (pwm0) hi++;
      if (pwmn0) nhi++;
      @(negedge clk);
    end
    n_checks++;
    if ({hi, nhi} !== {32'd255, 32'd0}) begin
      n_fail++; $display("FAIL duty255 got hi=%0d nhi=%0d expected 255 0", hi, nhi);
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int n_ps, nhi;
    duty_in = 8'd64;
    wait_ps(0, 300, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ps0_timeout got none expected pulse within 300 clk"); end
    repeat (100) @(negedge clk);
    enable = 1'b0;
    n_ps = 0; nhi = 0;
    for (int i = 0; i < 13000; i++) begin
      @(negedge clk);
      if (ps0 || ps1) n_ps++;
      if (pwmn0) nhi++;
    end
    n_checks++;
    if (nhi !== 155) begin n_fail++; $display("FAIL drop_complete got %0d expected 155", nhi); end
    n_checks++;
    if (n_ps !== 0) begin n_fail++; $display("FAIL drop_no_ps got %0d expected 0", n_ps); end
    n_checks++;
    if ({pwm0, pwmn0, pwm1, pwmn1} !== 4'b0000) begin
      n_fail++; $display("FAIL drop_idle got %b expected 0000", {pwm0, pwmn0, pwm1, pwmn1});
    end
    enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ps0, ps1, da0} !== {1'b1, 1'b1, 8'd64}) begin
      n_fail++; $display("FAIL reenable got ps0=%b ps1=%b duty=%0d expected 1 1 64", ps0, ps1, da0);
    end
  endtask

  task automatic test_reset_mid();
    repeat (50) @(negedge clk);
    n_checks++;
    if (pwm0 !== 1'b1) begin n_fail++; $display("FAIL pre_reset_high got %b expected 1", pwm0); end
    #2;
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    n_checks++;
    if ({pwm0, pwmn0, pwm1, pwmn1, ps0, da0} !== 13'd0) begin
      n_fail++; $display("FAIL async_reset got %b expected all zero", {pwm0, pwmn0, pwm1, pwmn1, ps0, da0});
    end
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({da0, da1, ps0, pwm0, pwmn0} !== 19'd0) begin
      n_fail++; $display("FAIL post_reset_idle got %b expected all zero", {da0, da1, ps0, pwm0, pwmn0});
    end
  endtask

  task automatic test_random();
    enable = 1'b1;
    for (int it = 0; it < 12; it++) begin
      duty_in = 8'($urandom_range(0, 255));
      enable  = ($urandom_range(0, 4) != 0);
      repeat ($urandom_range(20, 1500)) @(negedge clk);
      n_checks++;
      if ({da0, pwm0, pwmn0, da1, pwm1, pwmn1} !==
          {8'(m_duty[0]), m_out[0], m_nout[0], 8'(m_duty[1]), m_out[1], m_nout[1]}) begin
        n_fail++;
        $display("FAIL random_%0d got %0d %b%b %0d %b%b expected %0d %b%b %0d %b%b", it,
                 da0, pwm0, pwmn0, da1, pwm1, pwmn1,
                 m_duty[0], m_out[0], m_nout[0], m_duty[1], m_out[1], m_nout[1]);
      end
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_duty64();
    test_duty_change();
    test_extremes();
    test_enable_drop();
    test_reset_mid();
    test_random();
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
